dcache: RTL
===========

// Module: dcache
// PURPOSE
//  Direct-mapped, write-through, no-write-allocate data cache. Sits between the
//  cpu data port (ram_*) and data_ram in top. Serves read hits combinationally
//  with no stall. Read misses and all writes go to the backing memory through a
//  ce/ack handshake, and the cpu is held with stall_o until they complete.
// PARAMETERS
//  LINES      16  number of one-word lines; power of 2; index = addr[IDXW+1:2]
//  IDXW        4  log2(LINES)
//  CNTW       16  width of hit/miss counters
// PORTS
//  clk         in   1   system clock; all state changes on posedge
//  rst         in   1   synchronous, active-high reset
//  ce_i        in   1   cpu request valid
//  we_i        in   1   1 = write, 0 = read
//  addr_i      in   32  byte address; addr_i[1:0] ignored
//  sel_i       in   4   byte enables; sel_i[3] = bits 31:24
//  data_i      in   32  cpu write data
//  data_o      out  32  read data; valid when ce_i & !we_i & !stall_o
//  stall_o     out  1   cpu must hold ce/we/addr/sel/data stable while 1
//  mem_ce_o    out  1   backing-memory request, registered
//  mem_we_o    out  1   backing-memory write strobe
//  mem_addr_o  out  32  word-aligned address ({addr_i[31:2],2'b00})
//  mem_sel_o   out  4   byte enables; 4'b1111 on reads
//  mem_data_o  out  32  write data
//  mem_data_i  in   32  read data; valid with mem_ack_i
//  mem_ack_i   in   1   one-cycle completion pulse; latency 1..N cycles
//  hit_cnt_o   out  CNTW  read hits, saturating
//  miss_cnt_o  out  CNTW  read misses, saturating
// BEHAVIOUR
//  - Reset: all valid bits 0, state IDLE, all mem_* 0, counters 0, data_o 0.
//  - tag = addr_i[31:IDXW+2]. hit = valid[idx] & (tag_arr[idx] == tag).
//  - stall_o (combinational) = (IDLE & ce_i & (we_i | !hit)) | RD | WR.
//    stall_o is 0 in DONE.
//  - State machine:
//    IDLE: ce_i=0 -> stay in IDLE.
//          read hit -> data_o = data_arr[idx]; hit_cnt++; stay in IDLE.
//          read miss -> RD; miss_cnt++.
//          write -> WR.
//    RD:   mem_ce_o=1, mem_we_o=0, mem_sel_o=4'hF.
//          On mem_ack_i: line[idx] <= {1, tag, mem_data_i}; -> IDLE.
//          The next cycle is a read hit, which releases the stall and
//          increments hit_cnt. Miss latency = ack latency + 2 cycles.
//    WR:   mem_ce_o=1, mem_we_o=1, sel and data passed through.
//          On mem_ack_i: if hit, merge data_i bytes selected by sel_i into
//          data_arr[idx]; on a miss the line is untouched (no allocate); -> DONE.
//    DONE: stall_o=0, mem_ce_o=0, one cycle; -> IDLE. Prevents the cpu's
//          still-asserted write from being re-issued.
//  - mem_ce_o and mem_we_o are registered and drop in the cycle after the ack.
//    mem_ack_i outside RD/WR is ignored.
//  - A write with sel_i=0 still performs the handshake; data is unchanged.
//  - Index alias: a read miss evicts the old line unconditionally. There is
//    never dirty data, so nothing is written back.
//  - rst asserted mid-RD/WR: next state IDLE, mem_ce_o=0 the next cycle, valid
//    cleared. A late ack after reset is ignored.
//  - Counters saturate at all-ones and do not wrap.
// STRUCTURE
//  - header.v gains: `DcStateBus and state codes IDLE/RD/WR/DONE, `DcLines,
//    `DcIdxW. It reuses `RegBus, `RstEnable, `ChipEnable, `WriteEnable.
//  - Sub-module dcache_line_store: valid/tag/data arrays; async read, sync
//    write with byte merge, sync clear of valid on rst.
//  - top inserts dcache between cpu0 ram_* ports and data_ram0.
//  - data_ram0 is wrapped to return mem_ack_i one cycle after ce.
//  - cpu consumes stall_o as a pipeline-hold request.
// TESTING
//  1 Reset, then read 0x100 with ack latency 3 -> stall_o high 5 cycles,
//    then data_o = mem word; miss_cnt=1, hit_cnt=1.
//  2 Read 0x100 again -> stall_o=0 in the same cycle; no mem_ce_o;
//    hit_cnt=2.
//  3 Write 0x100 sel=4'b0011 data=0xAABBCCDD over cached 0x11223344 ->
//    mem_we_o pulse; one-cycle DONE; a following read returns 0x1122CCDD
//    with no stall.
//  4 Write miss 0x200 then read 0x200 -> write does not allocate; the read
//    misses (miss_cnt++). Also read 0x140 (same idx as 0x100) ->
//    0x100 evicted; the next 0x100 read misses.
//  5 Assert rst during RD before ack, then give a late ack -> state IDLE,
//    valid all 0, mem_ce_o=0, no fill.
//  6 Run 70000 read hits -> hit_cnt_o = 16'hFFFF (saturated).

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped write-through data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRd   = 2'd1,
    StWr   = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned SelW  = 4;

  function automatic logic [DataW-1:0] merge_bytes(input logic [DataW-1:0] old_word,
                                                   input logic [DataW-1:0] new_word,
                                                   input logic [SelW-1:0]  sel);
    logic [DataW-1:0] res;
    res = old_word;
    for (int b = 0; b < SelW; b++) begin
      if (sel[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Valid/tag/data arrays for the cache: async read, sync fill or byte-merged write.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned IDXW  = 4,
  parameter int unsigned TAGW  = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDXW-1:0]  idx,
  output logic             valid,
  output logic [TAGW-1:0]  tag,
  output logic [DataW-1:0] data,
  input  logic             fill_en,
  input  logic [TAGW-1:0]  fill_tag,
  input  logic [DataW-1:0] fill_data,
  input  logic             wr_en,
  input  logic [SelW-1:0]  wr_sel,
  input  logic [DataW-1:0] wr_data
);

  logic [LINES-1:0] valid_q;
  logic [TAGW-1:0]  tag_q  [LINES];
  logic [DataW-1:0] data_q [LINES];

  assign valid = valid_q[idx];
  assign tag   = tag_q[idx];
  assign data  = data_q[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[idx] <= 1'b1;
    end
  end

  // Tag/data carry no reset; a cleared valid bit makes their contents irrelevant.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[idx]  <= fill_tag;
      data_q[idx] <= fill_data;
    end else if (wr_en) begin
      data_q[idx] <= merge_bytes(data_q[idx], wr_data, wr_sel);
    end
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache between cpu and data ram.
module dcache
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = 16,
  parameter int unsigned IDXW  = 4,
  parameter int unsigned CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [SelW-1:0]  sel_i,
  input  logic [DataW-1:0] data_i,
  output logic [DataW-1:0] data_o,
  output logic             stall_o,
  output logic             mem_ce_o,
  output logic             mem_we_o,
  output logic [AddrW-1:0] mem_addr_o,
  output logic [SelW-1:0]  mem_sel_o,
  output logic [DataW-1:0] mem_data_o,
  input  logic [DataW-1:0] mem_data_i,
  input  logic             mem_ack_i,
  output logic [CNTW-1:0]  hit_cnt_o,
  output logic [CNTW-1:0]  miss_cnt_o
);

  localparam int unsigned TagW = AddrW - IDXW - 2;

  state_e state_q, state_d;

  logic [IDXW-1:0]  idx;
  logic [TagW-1:0]  tag;
  logic             line_valid;
  logic [TagW-1:0]  line_tag;
  logic [DataW-1:0] line_data;
  logic             hit;
  logic             fill_en, wr_en, count_hit, count_miss;
  logic [CNTW-1:0]  hit_cnt_q, miss_cnt_q;
  logic             unused_addr_lsb;

  assign idx             = addr_i[IDXW+1:2];
  assign tag             = addr_i[AddrW-1:IDXW+2];
  assign hit             = line_valid & (line_tag == tag);
  assign unused_addr_lsb = ^addr_i[1:0];

  dcache_line_store #(
    .LINES(LINES),
    .IDXW (IDXW),
    .TAGW (TagW)
  ) u_line_store (
    .clk      (clk),
    .rst      (rst),
    .idx      (idx),
    .valid    (line_valid),
    .tag      (line_tag),
    .data     (line_data),
    .fill_en  (fill_en),
    .fill_tag (tag),
    .fill_data(mem_data_i),
    .wr_en    (wr_en),
    .wr_sel   (sel_i),
    .wr_data  (data_i)
  );

  assign data_o = (ce_i & ~we_i & hit) ? line_data : '0;

  always_comb begin
    state_d    = state_q;
    stall_o    = 1'b0;
    fill_en    = 1'b0;
    wr_en      = 1'b0;
    count_hit  = 1'b0;
    count_miss = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ce_i) begin
          if (we_i) begin
            stall_o = 1'b1;
            state_d = StWr;
          end else if (hit) begin
            count_hit = 1'b1;
          end else begin
            stall_o    = 1'b1;
            count_miss = 1'b1;
            state_d    = StRd;
          end
        end
      end
      StRd: begin
        stall_o = 1'b1;
        if (mem_ack_i) begin
          fill_en = 1'b1;
          state_d = StIdle;
        end
      end
      StWr: begin
        stall_o = 1'b1;
        if (mem_ack_i) begin
          wr_en   = hit;
          state_d = StDone;
        end
      end
      // One idle cycle so the cpu's still-held write is not reissued.
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      mem_ce_o   <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_addr_o <= '0;
      mem_sel_o  <= '0;
      mem_data_o <= '0;
    end else begin
      state_q  <= state_d;
      mem_ce_o <= (state_d == StRd) | (state_d == StWr);
      mem_we_o <= (state_d == StWr);
      if (state_q == StIdle && state_d == StRd) begin
        mem_addr_o <= {addr_i[AddrW-1:2], 2'b00};
        mem_sel_o  <= '1;
        mem_data_o <= '0;
      end else if (state_q == StIdle && state_d == StWr) begin
        mem_addr_o <= {addr_i[AddrW-1:2], 2'b00};
        mem_sel_o  <= sel_i;
        mem_data_o <= data_i;
      end else if (state_d == StIdle || state_d == StDone) begin
        mem_addr_o <= '0;
        mem_sel_o  <= '0;
        mem_data_o <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (count_hit && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + CNTW'(1);
      if (count_miss && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNTW'(1);
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

endmodule
